// File: rtl/flappy_pkg.sv
// Screen and gameplay constants shared by the flappy game blocks.
package flappy_pkg;

    localparam int COORD_W  = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIPE_W   = 52;
    localparam int GAP_H    = 120;
    localparam int SPACING  = 240;
    localparam int SPEED    = 2;
    localparam int Y_MIN    = 60;
    localparam int Y_INIT   = 180;
    localparam int NUM_PIPES = 3;

    typedef logic [COORD_W-1:0] coord_t;

    // Random slice for pipe k: pipes 0/1/2 take lfsr[7:0]/[11:4]/[15:8].
    function automatic logic [7:0] rand_slice(input logic [15:0] lfsr, input int k);
        logic [7:0] r;
        case (k)
            0:       r = lfsr[7:0];
            1:       r = lfsr[11:4];
            default: r = lfsr[15:8];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_r;
    logic [15:0] state_next_s;

    // Right-shift Galois step: feedback bit folds into taps 15,13,12,10.
    always_comb begin
        state_next_s = {1'b0, state_r[15:1]};
        if (state_r[0]) begin
            state_next_s = state_next_s ^ 16'hB400;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEED;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/pipe_generate.sv
// Scrolls three pipe obstacles left once per frame and respawns them off the
// right edge with pseudo-random gap heights.
module pipe_generate
    import flappy_pkg::*;
#(
    parameter int          H_ACTIVE_P = H_ACTIVE,
    parameter int          PIPE_W_P   = PIPE_W,
    parameter int          SPACING_P  = SPACING,
    parameter int          SPEED_P    = SPEED,
    parameter int          Y_MIN_P    = Y_MIN,
    parameter int          Y_INIT_P   = Y_INIT,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vs,
    input  logic                 play,
    input  logic                 waiting,
    output logic [COORD_W-1:0]   pipe1_x,
    output logic [COORD_W-1:0]   pipe1_y,
    output logic [COORD_W-1:0]   pipe2_x,
    output logic [COORD_W-1:0]   pipe2_y,
    output logic [COORD_W-1:0]   pipe3_x,
    output logic [COORD_W-1:0]   pipe3_y,
    output logic                 frame_tick
);

    localparam coord_t SPEED_C   = coord_t'(SPEED_P);
    localparam coord_t RESPAWN_C = coord_t'(32'd3 * SPACING_P - SPEED_P);
    localparam coord_t Y_MIN_C   = coord_t'(Y_MIN_P);
    localparam coord_t Y_INIT_C  = coord_t'(Y_INIT_P);

    function automatic coord_t x_init(input int k);
        return coord_t'(H_ACTIVE_P + PIPE_W_P + k * SPACING_P);
    endfunction

    logic        vs_d_r;
    logic        frame_tick_r;
    logic [15:0] lfsr_s;
    coord_t      x_r      [NUM_PIPES];
    coord_t      y_r      [NUM_PIPES];
    coord_t      x_next_s [NUM_PIPES];
    coord_t      y_next_s [NUM_PIPES];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_s)
    );

    // Frame edge detector; the tick is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r       <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            vs_d_r       <= vs;
            frame_tick_r <= vs & ~vs_d_r;
        end
    end

    // Next pipe layout: waiting reloads, a playing tick scrolls, else hold.
    always_comb begin
        for (int k = 0; k < NUM_PIPES; k++) begin
            x_next_s[k] = x_r[k];
            y_next_s[k] = y_r[k];
        end
        if (waiting) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_next_s[k] = x_init(k);
                y_next_s[k] = Y_INIT_C;
            end
        end else if (play && frame_tick_r) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                if (x_r[k] > SPEED_C) begin
                    x_next_s[k] = x_r[k] - SPEED_C;
                end else begin
                    // Adding 3*SPACING-SPEED keeps the pipe spacing exact.
                    x_next_s[k] = x_r[k] + RESPAWN_C;
                    y_next_s[k] = Y_MIN_C + {4'b0000, rand_slice(lfsr_s, k)};
                end
            end
        end else begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_next_s[k] = x_r[k];
                y_next_s[k] = y_r[k];
            end
        end
    end

    // Pipe position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_r[k] <= x_init(k);
                y_r[k] <= Y_INIT_C;
            end
        end else begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                x_r[k] <= x_next_s[k];
                y_r[k] <= y_next_s[k];
            end
        end
    end

    assign pipe1_x    = x_r[0];
    assign pipe1_y    = y_r[0];
    assign pipe2_x    = x_r[1];
    assign pipe2_y    = y_r[1];
    assign pipe3_x    = x_r[2];
    assign pipe3_y    = y_r[2];
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_pipe_generate.sv
// Directed bench for pipe_generate with an independent LFSR reference model.
module tb_pipe_generate;

    logic        clk;
    logic        rst_n;
    logic        vs;
    logic        play;
    logic        waiting;
    logic [11:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y, pipe3_x, pipe3_y;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_cap;
    logic [11:0] y1_exp;
    int          tick_cnt;

    pipe_generate dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .play       (play),
        .waiting    (waiting),
        .pipe1_x    (pipe1_x),
        .pipe1_y    (pipe1_y),
        .pipe2_x    (pipe2_x),
        .pipe2_y    (pipe2_y),
        .pipe3_x    (pipe3_x),
        .pipe3_y    (pipe3_y),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR written tap-by-tap from the polynomial.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m <= 16'hACE1;
        end else begin
            lfsr_m[15]   <= lfsr_m[0];
            lfsr_m[14]   <= lfsr_m[15];
            lfsr_m[13]   <= lfsr_m[14] ^ lfsr_m[0];
            lfsr_m[12]   <= lfsr_m[13] ^ lfsr_m[0];
            lfsr_m[11]   <= lfsr_m[12];
            lfsr_m[10]   <= lfsr_m[11] ^ lfsr_m[0];
            lfsr_m[9:0]  <= lfsr_m[10:1];
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_layout(input string tag,
                                input logic [11:0] x1, input logic [11:0] y1,
                                input logic [11:0] x2, input logic [11:0] y2,
                                input logic [11:0] x3, input logic [11:0] y3);
        check({tag, "_p1x"}, pipe1_x, x1);
        check({tag, "_p1y"}, pipe1_y, y1);
        check({tag, "_p2x"}, pipe2_x, x2);
        check({tag, "_p2y"}, pipe2_y, y2);
        check({tag, "_p3x"}, pipe3_x, x3);
        check({tag, "_p3y"}, pipe3_y, y3);
    endtask

    // One vs pulse; captures the model LFSR in the frame_tick cycle.
    task automatic vs_pulse();
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1 lfsr_cap = lfsr_m;
        @(negedge clk);
        vs = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        vs      = 1'b0;
        play    = 1'b0;
        waiting = 1'b0;
        lfsr_cap = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset layout, then idle for 100 cycles.
        #1 check_layout("reset", 12'd692, 12'd180, 12'd932, 12'd180, 12'd1172, 12'd180);
        check("reset_tick", {11'd0, frame_tick}, 12'd0);
        repeat (100) @(posedge clk);
        #1 check_layout("idle", 12'd692, 12'd180, 12'd932, 12'd180, 12'd1172, 12'd180);

        // Ten frames of play.
        play = 1'b1;
        for (int i = 0; i < 10; i++) vs_pulse();
        check_layout("play10", 12'd672, 12'd180, 12'd912, 12'd180, 12'd1152, 12'd180);

        // vs held high: exactly one tick.
        tick_cnt = 0;
        @(negedge clk);
        vs = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1 if (frame_tick) tick_cnt++;
        end
        @(negedge clk);
        vs = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("vs_held_ticks", 12'(tick_cnt), 12'd1);
        check_layout("vs_held", 12'd670, 12'd180, 12'd910, 12'd180, 12'd1150, 12'd180);

        // Scroll pipe 1 down to the respawn boundary.
        for (int i = 0; i < 334; i++) vs_pulse();
        check_layout("pre_respawn", 12'd2, 12'd180, 12'd242, 12'd180, 12'd482, 12'd180);

        // Respawn of pipe 1 with gap from lfsr[7:0].
        vs_pulse();
        y1_exp = 12'd60 + {4'd0, lfsr_cap[7:0]};
        check_layout("respawn", 12'd720, y1_exp, 12'd240, 12'd180, 12'd480, 12'd180);

        // Game over: frozen through 20 frames.
        play = 1'b0;
        for (int i = 0; i < 20; i++) vs_pulse();
        check_layout("gameover", 12'd720, y1_exp, 12'd240, 12'd180, 12'd480, 12'd180);

        // Waiting wins over a simultaneous tick.
        play = 1'b1;
        vs_pulse();
        check_layout("resume", 12'd718, y1_exp, 12'd238, 12'd180, 12'd478, 12'd180);
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1 check("wait_tick", {11'd0, frame_tick}, 12'd1);
        @(negedge clk);
        vs      = 1'b0;
        waiting = 1'b1;
        @(posedge clk);
        #1 check_layout("waiting", 12'd692, 12'd180, 12'd932, 12'd180, 12'd1172, 12'd180);
        @(negedge clk);
        waiting = 1'b0;

        // Asynchronous reset mid-play.
        vs_pulse();
        check_layout("preasync", 12'd690, 12'd180, 12'd930, 12'd180, 12'd1170, 12'd180);
        vs_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_layout("async_rst", 12'd692, 12'd180, 12'd932, 12'd180, 12'd1172, 12'd180);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_layout("post_rst", 12'd692, 12'd180, 12'd932, 12'd180, 12'd1172, 12'd180);
        vs_pulse();
        check_layout("post_rst_tick", 12'd690, 12'd180, 12'd930, 12'd180, 12'd1170, 12'd180);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_generate.md
Name: pipe_generate

Overview:
- Upstream producer of the three pipe obstacles consumed by the game FSM and the crash/pass checker.
- Scrolls three pipes leftward once per video frame while the game is playing.
- Respawns each pipe off the right screen edge with a pseudo-random gap height.
- Holds the initial layout while waiting; freezes positions at game over.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- PIPE_W, 52, pipe width in pixels
- SPACING, 240, right-edge distance between consecutive pipes; 3*SPACING must be >= H_ACTIVE+PIPE_W
- SPEED, 2, pixels moved per frame tick; must be < PIPE_W
- Y_MIN, 60, smallest gap-top row
- Y_INIT, 180, gap-top row of all pipes after reset or while waiting
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- vs  in  1  vertical sync, active high; its rising edge marks one frame
- play  in  1  game in playing state
- waiting  in  1  game in idle/waiting state
- pipe1_x  out  12  pipe 1 right-edge column (left edge = x - PIPE_W)
- pipe1_y  out  12  pipe 1 gap-top row
- pipe2_x  out  12  pipe 2 right-edge column
- pipe2_y  out  12  pipe 2 gap-top row
- pipe3_x  out  12  pipe 3 right-edge column
- pipe3_y  out  12  pipe 3 gap-top row
- frame_tick  out  1  one-cycle pulse on each vs rising edge, for debug/score use

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values:
  - pipe_k_x = H_ACTIVE + PIPE_W + (k-1)*SPACING, giving 692, 932 and 1172 at defaults.
  - pipe_k_y = Y_INIT.
  - LFSR = LFSR_SEED; vs_d = 0; frame_tick = 0.
- Frame tick:
  - vs_d registers vs every cycle.
  - frame_tick is registered: it is 1 in the cycle after vs=1 && vs_d=0.
  - vs held high gives exactly one tick.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle regardless of play, so gap heights depend on start timing.
- Mode priority per cycle, evaluated in this order:
  1. waiting=1: all pipes are reloaded to their reset x/y values, synchronously in the next cycle, ticks ignored.
  2. play=1 and frame_tick=1: pipes scroll as described below.
  3. Otherwise, including game over (play=0, waiting=0): all pipe registers hold.
- Scroll, each pipe independent, per tick:
  - If pipe_k_x > SPEED: pipe_k_x -= SPEED.
  - Else (respawn): pipe_k_x = pipe_k_x + 3*SPACING - SPEED, which preserves spacing exactly, and pipe_k_y = Y_MIN + r_k.
  - r_1 = lfsr[7:0], r_2 = lfsr[11:4], r_3 = lfsr[15:8].
  - Gap-top range is therefore Y_MIN..Y_MIN+255 (60..315 at defaults).
- Arithmetic:
  - All x/y are 12-bit unsigned; no wrap is possible under the parameter constraints.
  - The x > SPEED compare is unsigned.
- Latency: pipe outputs update one cycle after frame_tick, i.e. two cycles after the vs rising edge.
- Simultaneous respawns: each pipe uses its own slice; both respawn in the same cycle.
- Reset mid-frame or mid-respawn: all state returns to reset values immediately.
  - The first tick after reset requires a fresh vs rising edge (vs_d is cleared by reset).
- Outputs are registered and glitch-free.

Decomposition:
- Shared package flappy_pkg holds the screen and gameplay constants used by the bird, crash and render blocks:
  - H_ACTIVE, V_ACTIVE, PIPE_W, GAP_H, SPACING, SPEED, Y_MIN, Y_INIT.
  - Coordinate width: 12.
- One sub-module, lfsr16, with ports clk, rst_n, seed param and 16-bit state out. It is reused later for other random features.

Test Plan:
- Reset release with vs=0 and play=0:
  - pipe1_x/2_x/3_x = 692/932/1172; all y = 180.
  - No change over 100 cycles.
- play=1, ten vs pulses:
  - pipe1_x = 672, pipe2_x = 912, pipe3_x = 1152.
  - Hold vs high for 50 cycles: exactly one further decrement, to 670.
- Respawn: drive play until pipe1_x = 2, then one more tick:
  - pipe1_x = 720.
  - pipe1_y = 60 + lfsr[7:0] sampled in the tick cycle, checked by a bench LFSR model; pipe2/pipe3 only decrement by 2.
- Game over, play=0 and waiting=0, with 20 vs pulses: all six outputs are unchanged.
- Assert waiting=1 mid-game: next cycle, outputs equal the reset layout (692/932/1172, y = 180), even with a simultaneous frame_tick.
- Assert rst_n low asynchronously between clock edges, mid-play: outputs go to reset values without a clock edge.
  - After release, no scroll occurs until a new vs rising edge.
